// File: rtl/seg_scan_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_receiver_pkg
// Purpose  : Shared constants and types for the seven-segment scan receiver.
//            Holds the active-low segment codes for digits 0..9 on segs[6:0],
//            the bit positions of the digit anodes on the anode bus, and the
//            state encoding of the capture FSM.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_receiver_pkg;

    localparam int c_NUM_DIGITS = 4;

    // Digit anodes occupy annode_select[7:4]; [3:0] are unused and idle high.
    localparam int c_ANODE_LSB = 4;
    localparam int c_ANODE_MSB = 7;

    // Active-low segment codes, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] c_SEG_0 = 7'h40;
    localparam logic [6:0] c_SEG_1 = 7'h79;
    localparam logic [6:0] c_SEG_2 = 7'h24;
    localparam logic [6:0] c_SEG_3 = 7'h30;
    localparam logic [6:0] c_SEG_4 = 7'h19;
    localparam logic [6:0] c_SEG_5 = 7'h12;
    localparam logic [6:0] c_SEG_6 = 7'h02;
    localparam logic [6:0] c_SEG_7 = 7'h78;
    localparam logic [6:0] c_SEG_8 = 7'h00;
    localparam logic [6:0] c_SEG_9 = 7'h10;

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,   // waiting for a sample to dwell long enough
        ST_HOLD  = 1'b1    // current dwell already classified
    } state_t;

endpackage : seg_scan_receiver_pkg
`default_nettype wire

// File: rtl/seg_scan_receiver_seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Purpose  : Combinational decode of an active-low seven-segment pattern
//            back to a BCD digit. Any pattern that is not one of the ten
//            digit codes reports legal_o = 0 and digit_o = 0.
// Ports    : seg_i   [6:0] active-low segments a..g
//            digit_o [3:0] decoded BCD digit
//            legal_o       pattern is one of the ten digit codes
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg_scan_receiver_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b1;
        case (seg_i)
            c_SEG_0: digit_o = 4'd0;
            c_SEG_1: digit_o = 4'd1;
            c_SEG_2: digit_o = 4'd2;
            c_SEG_3: digit_o = 4'd3;
            c_SEG_4: digit_o = 4'd4;
            c_SEG_5: digit_o = 4'd5;
            c_SEG_6: digit_o = 4'd6;
            c_SEG_7: digit_o = 4'd7;
            c_SEG_8: digit_o = 4'd8;
            c_SEG_9: digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/seg_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_receiver
// Purpose  : Monitors a multiplexed four-digit seven-segment bus. Each
//            stable dwell of {anodes, segments} is classified once; legal
//            digits are assembled into a frame which is published as BCD and
//            binary together with a one-cycle frame_valid pulse. Sticky flags
//            report illegal segment patterns and bad anode combinations, and
//            stale reports a long absence of legal captures.
// Ports    : sysclock            system clock (posedge)
//            reset               synchronous active-high reset
//            segs[7:0]           active-low segments, [7]=dp ignored
//            annode_select[7:0]  active-low anodes, [4]=digit0..[7]=digit3
//            err_clr             pulse, clears seg_err and mux_err
//            bcd_value[15:0]     {digit3,digit2,digit1,digit0}
//            bin_value[13:0]     binary value of bcd_value
//            frame_valid         one-cycle pulse on frame update
//            seg_err, mux_err    sticky error flags
//            stale               no legal capture for TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_receiver
    import seg_scan_receiver_pkg::*;
#(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1048576,
    parameter int TO_W    = 21
) (
    input  logic        sysclock,
    input  logic        reset,
    input  logic [7:0]  segs,
    input  logic [7:0]  annode_select,
    input  logic        err_clr,
    output logic [15:0] bcd_value,
    output logic [13:0] bin_value,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        mux_err,
    output logic        stale
);

    localparam int              c_CNT_W  = $clog2(SETTLE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_CNT_FIRE = c_CNT_W'(SETTLE - 1);
    localparam logic [TO_W-1:0]    c_TO_MAX   = TO_W'(TIMEOUT);

    // Sample layout: [14:11] = digit anodes, [10:7] = unused anodes, [6:0] = segments
    logic [14:0]                    smp_q;
    logic [14:0]                    prev_q;
    logic [c_CNT_W-1:0]             cnt_q;
    logic [TO_W-1:0]                to_cnt_q;
    state_t                         state_q;
    logic [c_NUM_DIGITS-1:0]        seen_q;
    logic [c_NUM_DIGITS-1:0]        seen_d;
    logic [c_NUM_DIGITS-1:0][3:0]   digits_q;
    logic [15:0]                    bcd_q;
    logic [13:0]                    bin_q;
    logic                           frame_valid_q;
    logic                           seg_err_q;
    logic                           mux_err_q;

    logic [c_NUM_DIGITS-1:0]        w_an_low;
    logic                           w_aux_ok;
    logic [3:0]                     w_dig;
    logic                           w_legal;
    logic                           w_stable;
    logic                           w_fire;
    logic                           w_single;
    logic                           w_blank;
    logic                           w_cap;
    logic                           w_seg_evt;
    logic                           w_mux_evt;
    logic                           w_frame_done;
    logic [13:0]                    w_bin;

    // ------------------------------------------------------------------
    // Classification of the current sample
    // ------------------------------------------------------------------
    assign w_an_low = ~smp_q[14:11];
    assign w_aux_ok = (smp_q[10:7] == 4'hF);
    assign w_stable = (smp_q == prev_q);

    seg7_decoder u_dec (
        .seg_i   (smp_q[6:0]),
        .digit_o (w_dig),
        .legal_o (w_legal)
    );

    // Fires exactly once per dwell: HOLD blocks re-firing until the sample moves.
    assign w_fire    = (state_q == ST_TRACK) && (cnt_q == c_CNT_FIRE) && w_stable;
    assign w_single  = $onehot(w_an_low);
    assign w_blank   = (w_an_low == '0);
    assign w_cap     = w_fire && w_aux_ok && w_single && w_legal;
    assign w_seg_evt = w_fire && w_aux_ok && w_single && !w_legal;
    assign w_mux_evt = w_fire && (!w_aux_ok || (!w_single && !w_blank));

    assign w_frame_done = (seen_q == '1);

    // A completed frame clears seen; a capture in the same cycle still lands.
    always_comb begin
        seen_d = w_frame_done ? '0 : seen_q;
        if (w_cap) begin
            seen_d = seen_d | w_an_low;
        end
    end

    assign w_bin = 14'(digits_q[3]) * 14'd1000
                 + 14'(digits_q[2]) * 14'd100
                 + 14'(digits_q[1]) * 14'd10
                 + 14'(digits_q[0]);

    // ------------------------------------------------------------------
    // Input sampling, dwell counter and capture timeout
    // ------------------------------------------------------------------
    always_ff @(posedge sysclock) begin
        if (reset) begin
            smp_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            smp_q  <= {annode_select, segs[6:0]};
            prev_q <= smp_q;

            if (!w_stable) begin
                cnt_q <= '0;
            end else if (cnt_q != c_CNT_MAX) begin
                cnt_q <= cnt_q + c_CNT_W'(1);
            end

            if (w_cap) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != c_TO_MAX) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM, frame assembly and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sysclock) begin
        if (reset) begin
            state_q       <= ST_TRACK;
            seen_q        <= '0;
            digits_q      <= '0;
            bcd_q         <= '0;
            bin_q         <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            mux_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_TRACK: if (w_fire)    state_q <= ST_HOLD;
                ST_HOLD:  if (!w_stable) state_q <= ST_TRACK;
                default:                 state_q <= ST_TRACK;
            endcase

            for (int i = 0; i < c_NUM_DIGITS; i++) begin
                if (w_cap && w_an_low[i]) begin
                    digits_q[i] <= w_dig;
                end
            end
            seen_q <= seen_d;

            frame_valid_q <= w_frame_done;
            if (w_frame_done) begin
                bcd_q <= digits_q;
                bin_q <= w_bin;
            end

            // A new event outranks a simultaneous clear.
            seg_err_q <= (seg_err_q && !err_clr) || w_seg_evt;
            mux_err_q <= (mux_err_q && !err_clr) || w_mux_evt;
        end
    end

    assign bcd_value   = bcd_q;
    assign bin_value   = bin_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign mux_err     = mux_err_q;
    assign stale       = (to_cnt_q == c_TO_MAX);

endmodule : seg_scan_receiver
`default_nettype wire
